// File: rtl/refill_pkg.sv
// Shared definitions for the cache-line refill controller: FSM states,
// beat count, address bit positions and the burst length sent to memory.
package refill_pkg;

    localparam int LINE_BITS  = 256;
    localparam int BEAT_BITS  = 32;
    localparam int BEATS      = LINE_BITS / BEAT_BITS;
    localparam int BEAT_CNT_W = $clog2(BEATS);

    // Byte address layout {tag, index, offset}
    localparam int OFFSET_W   = $clog2(LINE_BITS / 8);
    localparam int INDEX_LSB  = OFFSET_W;
    localparam int INDEX_W    = 3;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

    // Memory burst length field is "beats minus one"
    localparam logic [7:0] MEM_REQ_LEN = 8'(BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RECV  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } refill_state_e;

endpackage

// File: rtl/refill_ctrl_line_assembler.sv
// line_assembler: beat counter plus line register. Each load stores the
// beat at the slot selected by the counter; the counter saturates on the
// final slot so it can never wrap inside a refill.
module line_assembler #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [BEAT_W-1:0] beat_data,
    output logic [LINE_W-1:0] line,
    output logic              full
);

    localparam int NB    = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(NB);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NB - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;

    // Next counter/line: clear wins over load; load drops the beat into its slot
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (clear) begin
            cnt_d  = '0;
            line_d = '0;
        end else if (load) begin
            line_d[int'(cnt_q) * BEAT_W +: BEAT_W] = beat_data;
            if (cnt_q != LAST_SLOT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and line registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign line = line_q;
    assign full = (cnt_q == LAST_SLOT);

endmodule

// File: rtl/refill_ctrl.sv
// refill_ctrl: on a cache miss, issues one burst read, assembles the beats
// into a line and writes tag/data/valid into the selected victim way.
// Optional macro REFILL_BEAT_CHECK_EN: checks mem_rd_rsp_last against the
// beat count, flags a sticky refill_err and cuts the burst short on an
// early last (the line is then written with valid=0).
module refill_ctrl
    import refill_pkg::*;
#(
    parameter int TARRAY_DATA_WIDTH = 24,
    parameter int DARRAY_DATA_WIDTH = 256,
    parameter int ADDR_WIDTH        = 3,
    parameter int WAY_NUM           = 4,
    parameter int BEAT_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         refill_req_valid,
    output logic                         refill_req_ready,
    input  logic [31:0]                  refill_req_addr,
    input  logic [WAY_NUM-1:0]           refill_req_way,
    output logic                         refill_done,
    output logic                         refill_err,
    output logic                         mem_rd_req_valid,
    input  logic                         mem_rd_req_ready,
    output logic [31:0]                  mem_rd_req_addr,
    output logic [7:0]                   mem_rd_req_len,
    input  logic                         mem_rd_rsp_valid,
    output logic                         mem_rd_rsp_ready,
    input  logic [BEAT_WIDTH-1:0]        mem_rd_rsp_data,
    input  logic                         mem_rd_rsp_last,
    output logic [WAY_NUM-1:0]           way_wen,
    output logic [ADDR_WIDTH-1:0]        way_waddr,
    output logic                         way_wvalid,
    output logic [TARRAY_DATA_WIDTH-1:0] way_wtag,
    output logic [DARRAY_DATA_WIDTH-1:0] way_wdata
);

    refill_state_e                state_q, state_d;
    logic [TARRAY_DATA_WIDTH-1:0] tag_q, tag_d;
    logic [ADDR_WIDTH-1:0]        index_q, index_d;
    logic [WAY_NUM-1:0]           way_q, way_d;
    logic                         err_q, err_d;
    logic                         wvalid_q, wvalid_d;

    logic                         asm_clear;
    logic                         asm_load;
    logic                         asm_full;
    logic [DARRAY_DATA_WIDTH-1:0] asm_line;

    line_assembler #(
        .LINE_W (DARRAY_DATA_WIDTH),
        .BEAT_W (BEAT_WIDTH)
    ) u_line_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .load      (asm_load),
        .beat_data (mem_rd_rsp_data),
        .line      (asm_line),
        .full      (asm_full)
    );

    // Next-state and handshake/write-port outputs, decoded from the current state
    always_comb begin
        state_d          = state_q;
        tag_d            = tag_q;
        index_d          = index_q;
        way_d            = way_q;
        err_d            = err_q;
        wvalid_d         = wvalid_q;
        asm_clear        = 1'b0;
        asm_load         = 1'b0;
        refill_req_ready = 1'b0;
        refill_done      = 1'b0;
        mem_rd_req_valid = 1'b0;
        mem_rd_req_len   = 8'd0;
        mem_rd_rsp_ready = 1'b0;
        way_wen          = '0;
        way_wvalid       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                refill_req_ready = 1'b1;
                if (refill_req_valid) begin
                    tag_d     = refill_req_addr[31 -: TARRAY_DATA_WIDTH];
                    index_d   = refill_req_addr[INDEX_LSB +: ADDR_WIDTH];
                    way_d     = refill_req_way;
                    err_d     = 1'b0;
                    wvalid_d  = 1'b1;
                    asm_clear = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_rd_req_valid = 1'b1;
                mem_rd_req_len   = MEM_REQ_LEN;
                if (mem_rd_req_ready) begin
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                mem_rd_rsp_ready = 1'b1;
                if (mem_rd_rsp_valid) begin
                    asm_load = 1'b1;
`ifdef REFILL_BEAT_CHECK_EN
                    // last must coincide exactly with the final beat
                    if (mem_rd_rsp_last != asm_full) begin
                        err_d = 1'b1;
                    end
                    // early last: write what arrived, but mark the line invalid
                    if (mem_rd_rsp_last && !asm_full) begin
                        wvalid_d = 1'b0;
                        state_d  = ST_WRITE;
                    end
`endif
                    if (asm_full) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                way_wen    = way_q;
                way_wvalid = wvalid_q;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                refill_done = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tag_q    <= '0;
            index_q  <= '0;
            way_q    <= '0;
            err_q    <= 1'b0;
            wvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            index_q  <= index_d;
            way_q    <= way_d;
            err_q    <= err_d;
            wvalid_q <= wvalid_d;
        end
    end

    assign mem_rd_req_addr = {tag_q, index_q, {OFFSET_W{1'b0}}};
    assign way_waddr       = index_q;
    assign way_wtag        = tag_q;
    assign way_wdata       = asm_line;

`ifdef REFILL_BEAT_CHECK_EN
    assign refill_err = err_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^refill_req_addr[OFFSET_W-1:0];
`else
    assign refill_err = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{refill_req_addr[OFFSET_W-1:0], mem_rd_rsp_last, err_q};
`endif

endmodule

// File: tb/tb_refill_ctrl.sv
// Bench for refill_ctrl: directed scenarios plus randomized refills, each
// checked against expectations derived from the address layout and the
// beats the bench itself sends.
module tb_refill_ctrl;

`ifdef REFILL_BEAT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         refill_req_valid;
    logic         refill_req_ready;
    logic [31:0]  refill_req_addr;
    logic [3:0]   refill_req_way;
    logic         refill_done;
    logic         refill_err;
    logic         mem_rd_req_valid;
    logic         mem_rd_req_ready;
    logic [31:0]  mem_rd_req_addr;
    logic [7:0]   mem_rd_req_len;
    logic         mem_rd_rsp_valid;
    logic         mem_rd_rsp_ready;
    logic [31:0]  mem_rd_rsp_data;
    logic         mem_rd_rsp_last;
    logic [3:0]   way_wen;
    logic [2:0]   way_waddr;
    logic         way_wvalid;
    logic [23:0]  way_wtag;
    logic [255:0] way_wdata;

    int n_chk = 0;
    int n_bad = 0;

    refill_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .refill_req_valid (refill_req_valid),
        .refill_req_ready (refill_req_ready),
        .refill_req_addr  (refill_req_addr),
        .refill_req_way   (refill_req_way),
        .refill_done      (refill_done),
        .refill_err       (refill_err),
        .mem_rd_req_valid (mem_rd_req_valid),
        .mem_rd_req_ready (mem_rd_req_ready),
        .mem_rd_req_addr  (mem_rd_req_addr),
        .mem_rd_req_len   (mem_rd_req_len),
        .mem_rd_rsp_valid (mem_rd_rsp_valid),
        .mem_rd_rsp_ready (mem_rd_rsp_ready),
        .mem_rd_rsp_data  (mem_rd_rsp_data),
        .mem_rd_rsp_last  (mem_rd_rsp_last),
        .way_wen          (way_wen),
        .way_waddr        (way_waddr),
        .way_wvalid       (way_wvalid),
        .way_wtag         (way_wtag),
        .way_wdata        (way_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string p);
        chk({p, "_req_ready"}, 256'(refill_req_ready), 256'(1));
        chk({p, "_req_valid"}, 256'(mem_rd_req_valid), 256'(0));
        chk({p, "_req_addr"},  256'(mem_rd_req_addr),  256'(0));
        chk({p, "_req_len"},   256'(mem_rd_req_len),   256'(0));
        chk({p, "_rsp_ready"}, 256'(mem_rd_rsp_ready), 256'(0));
        chk({p, "_wen"},       256'(way_wen),          256'(0));
        chk({p, "_wvalid"},    256'(way_wvalid),       256'(0));
        chk({p, "_waddr"},     256'(way_waddr),        256'(0));
        chk({p, "_wtag"},      256'(way_wtag),         256'(0));
        chk({p, "_wdata"},     way_wdata,              256'(0));
        chk({p, "_done"},      256'(refill_done),      256'(0));
        chk({p, "_err"},       256'(refill_err),       256'(0));
    endtask

    // One refill transaction. gap_pct<0 means rsp_valid toggles every other
    // cycle; last_at is the beat index that carries last (8 = never);
    // rst_at>=0 pulses reset once beat rst_at has been accepted.
    task automatic do_refill(input logic [31:0] addr, input logic [3:0] way,
                             input int req_wait, input int gap_pct, input int last_at,
                             input bit keep, input bit seq_data, input int rst_at);
        logic [31:0]  beat [8];
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        int           nbeats, acc, guard;
        bit           early, exp_err, exp_wvalid, v;

        exp_addr   = {addr[31:5], 5'b0};
        early      = CHK_EN && (last_at < 7);
        exp_err    = CHK_EN && (last_at != 7);
        exp_wvalid = !early;
        nbeats     = early ? last_at + 1 : 8;
        exp_line   = '0;
        for (int k = 0; k < 8; k++) begin
            beat[k] = seq_data ? 32'(k) : $urandom;
            if (k < nbeats) exp_line = exp_line | (256'(beat[k]) << (32 * k));
        end

        refill_req_addr  = addr;
        refill_req_way   = way;
        refill_req_valid = 1'b1;
        chk("req_ready_idle", 256'(refill_req_ready), 256'(1));
        @(negedge clk);
        if (!keep) refill_req_valid = 1'b0;
        refill_req_addr = $urandom;
        refill_req_way  = 4'(1 << $urandom_range(3));

        chk("req_valid",      256'(mem_rd_req_valid), 256'(1));
        chk("req_addr",       256'(mem_rd_req_addr),  256'(exp_addr));
        chk("req_len",        256'(mem_rd_req_len),   256'(7));
        chk("err_clear",      256'(refill_err),       256'(0));
        chk("req_ready_busy", 256'(refill_req_ready), 256'(0));
        for (int i = 0; i < req_wait; i++) begin
            mem_rd_req_ready = 1'b0;
            @(negedge clk);
            chk("req_valid_hold",   256'(mem_rd_req_valid), 256'(1));
            chk("req_addr_hold",    256'(mem_rd_req_addr),  256'(exp_addr));
            chk("rsp_ready_in_req", 256'(mem_rd_rsp_ready), 256'(0));
        end
        mem_rd_req_ready = 1'b1;
        @(negedge clk);
        mem_rd_req_ready = 1'b0;
        chk("req_valid_drop", 256'(mem_rd_req_valid), 256'(0));

        acc   = 0;
        guard = 0;
        while (acc < nbeats && guard < 200) begin
            chk("rsp_ready", 256'(mem_rd_rsp_ready), 256'(1));
            chk("wen_recv",  256'(way_wen),          256'(0));
            if (gap_pct < 0) v = (guard % 2) == 1;
            else             v = ($urandom_range(99) >= gap_pct);
            mem_rd_rsp_valid = v;
            mem_rd_rsp_data  = v ? beat[acc] : $urandom;
            mem_rd_rsp_last  = v ? (acc == last_at) : 1'($urandom);
            @(negedge clk);
            guard++;
            if (v) acc++;
            if (rst_at >= 0 && acc == rst_at + 1) begin
                rst              = 1'b1;
                mem_rd_rsp_valid = 1'b1;
                mem_rd_rsp_data  = $urandom;
                @(negedge clk);
                check_idle("midrst");
                rst = 1'b0;
                @(negedge clk);
                chk("rsp_ready_after_rst", 256'(mem_rd_rsp_ready), 256'(0));
                chk("req_ready_after_rst", 256'(refill_req_ready), 256'(1));
                chk("wen_after_rst",       256'(way_wen),          256'(0));
                mem_rd_rsp_valid = 1'b0;
                return;
            end
        end
        mem_rd_rsp_valid = 1'b0;
        mem_rd_rsp_last  = 1'b0;
        chk("beats_in_budget", 256'(acc), 256'(nbeats));
        if (acc != nbeats) begin
            rst = 1'b1;
            refill_req_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            return;
        end

        chk("wen",             256'(way_wen),          256'(way));
        chk("waddr",           256'(way_waddr),        256'(addr[7:5]));
        chk("wtag",            256'(way_wtag),         256'(addr[31:8]));
        chk("wvalid",          256'(way_wvalid),       256'(exp_wvalid));
        if (exp_wvalid) chk("wdata", way_wdata, exp_line);
        chk("err_write",       256'(refill_err),       256'(exp_err));
        chk("done_early",      256'(refill_done),      256'(0));
        chk("rsp_ready_write", 256'(mem_rd_rsp_ready), 256'(0));
        @(negedge clk);
        chk("done",            256'(refill_done),      256'(1));
        chk("wen_done",        256'(way_wen),          256'(0));
        chk("err_done",        256'(refill_err),       256'(exp_err));
        chk("req_ready_done",  256'(refill_req_ready), 256'(0));
        @(negedge clk);
        chk("done_pulse",      256'(refill_done),      256'(0));
        chk("req_ready_back",  256'(refill_req_ready), 256'(1));
        chk("err_sticky",      256'(refill_err),       256'(exp_err));
        chk("wen_idle",        256'(way_wen),          256'(0));
        if (exp_wvalid) chk("wdata_hold", way_wdata, exp_line);
    endtask

    initial begin
        rst              = 1'b1;
        refill_req_valid = 1'b0;
        refill_req_addr  = '0;
        refill_req_way   = '0;
        mem_rd_req_ready = 1'b0;
        mem_rd_rsp_valid = 1'b0;
        mem_rd_rsp_data  = '0;
        mem_rd_rsp_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // zero-wait refill with sequential beats: done lands 11 cycles after acceptance
        do_refill(32'h123456E4, 4'b0100, 0, 0, 7, 1'b0, 1'b1, -1);
        // request stalled 5 cycles, response valid toggling
        do_refill($urandom, 4'b0001, 5, -1, 7, 1'b0, 1'b0, -1);
        // reset mid-burst, then a fresh refill
        do_refill($urandom, 4'b1000, 0, 0, 7, 1'b0, 1'b0, 4);
        do_refill($urandom, 4'b0010, 1, 30, 7, 1'b0, 1'b0, -1);
`ifdef REFILL_BEAT_CHECK_EN
        do_refill($urandom, 4'b0100, 0, 0, 5, 1'b0, 1'b0, -1);
        do_refill($urandom, 4'b0001, 0, 20, 7, 1'b0, 1'b0, -1);
        do_refill($urandom, 4'b0010, 0, 0, 8, 1'b0, 1'b0, -1);
`else
        do_refill($urandom, 4'b0100, 0, 0, 3, 1'b0, 1'b0, -1);
`endif
        // back-to-back with request valid held high
        do_refill($urandom, 4'b1000, 0, 0, 7, 1'b1, 1'b0, -1);
        do_refill($urandom, 4'b0100, 2, 10, 7, 1'b0, 1'b0, -1);

        for (int i = 0; i < 8; i++) begin
            do_refill($urandom, 4'(1 << $urandom_range(3)), $urandom_range(3),
                      $urandom_range(60), 7, (i < 7) ? 1'($urandom_range(1)) : 1'b0,
                      1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
